// File: rtl/morse_symbol_decoder.sv
// Morse symbol decoder: collects dot/dash codes of one letter and emits its
// ASCII character (A-Z, 0-9) as a registered one-cycle pulse on Space/EndSeq.
module morse_symbol_decoder #(
  parameter logic [7:0] ERR_CHAR      = 8'h3F,
  parameter bit         WORD_SPACE_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] Signals,
  output logic       char_valid,
  output logic [7:0] char_ascii,
  output logic       char_err,
  output logic       msg_end,
  output logic [2:0] sym_count
);

  localparam logic [2:0] SIG_DOT   = 3'b000;
  localparam logic [2:0] SIG_DASH  = 3'b001;
  localparam logic [2:0] SIG_SPACE = 3'b010;
  localparam logic [2:0] SIG_END   = 3'b011;
  localparam logic [2:0] SIG_IDLE  = 3'b111;

  typedef enum logic {S_COLLECT, S_END} state_t;

  state_t      state_q, state_d;
  logic [2:0]  prev_q;
  logic [4:0]  pat_q, pat_d;
  logic [2:0]  len_q, len_d;
  logic        ovf_q, ovf_d;
  logic        valid_q, valid_d;
  logic [7:0]  ascii_q, ascii_d;
  logic        err_q, err_d;
  logic        msg_q, msg_d;
  logic        accept;
  logic [8:0]  decoded;
  logic        letter_bad;

  // Returns {hit, ascii}; key is {len, pattern}, first symbol at bit len-1, dash = 1.
  function automatic logic [8:0] lookup(input logic [2:0] len, input logic [4:0] pat);
    logic [8:0] r;
    r = 9'h000;
    case ({len, pat})
      8'b001_00000: r = {1'b1, 8'h45}; // E
      8'b001_00001: r = {1'b1, 8'h54}; // T
      8'b010_00001: r = {1'b1, 8'h41}; // A
      8'b010_00000: r = {1'b1, 8'h49}; // I
      8'b010_00011: r = {1'b1, 8'h4D}; // M
      8'b010_00010: r = {1'b1, 8'h4E}; // N
      8'b011_00100: r = {1'b1, 8'h44}; // D
      8'b011_00110: r = {1'b1, 8'h47}; // G
      8'b011_00101: r = {1'b1, 8'h4B}; // K
      8'b011_00111: r = {1'b1, 8'h4F}; // O
      8'b011_00010: r = {1'b1, 8'h52}; // R
      8'b011_00000: r = {1'b1, 8'h53}; // S
      8'b011_00001: r = {1'b1, 8'h55}; // U
      8'b011_00011: r = {1'b1, 8'h57}; // W
      8'b100_01000: r = {1'b1, 8'h42}; // B
      8'b100_01010: r = {1'b1, 8'h43}; // C
      8'b100_00010: r = {1'b1, 8'h46}; // F
      8'b100_00000: r = {1'b1, 8'h48}; // H
      8'b100_00111: r = {1'b1, 8'h4A}; // J
      8'b100_00100: r = {1'b1, 8'h4C}; // L
      8'b100_00110: r = {1'b1, 8'h50}; // P
      8'b100_01101: r = {1'b1, 8'h51}; // Q
      8'b100_00001: r = {1'b1, 8'h56}; // V
      8'b100_01001: r = {1'b1, 8'h58}; // X
      8'b100_01011: r = {1'b1, 8'h59}; // Y
      8'b100_01100: r = {1'b1, 8'h5A}; // Z
      8'b101_11111: r = {1'b1, 8'h30}; // 0
      8'b101_01111: r = {1'b1, 8'h31}; // 1
      8'b101_00111: r = {1'b1, 8'h32}; // 2
      8'b101_00011: r = {1'b1, 8'h33}; // 3
      8'b101_00001: r = {1'b1, 8'h34}; // 4
      8'b101_00000: r = {1'b1, 8'h35}; // 5
      8'b101_10000: r = {1'b1, 8'h36}; // 6
      8'b101_11000: r = {1'b1, 8'h37}; // 7
      8'b101_11100: r = {1'b1, 8'h38}; // 8
      8'b101_11110: r = {1'b1, 8'h39}; // 9
      default:      r = 9'h000;
    endcase
    return r;
  endfunction

  assign accept     = (Signals <= SIG_END) && (Signals != prev_q);
  assign decoded    = lookup(len_q, pat_q);
  assign letter_bad = ovf_q || !decoded[8];

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    valid_d = 1'b0;
    ascii_d = ascii_q;
    err_d   = err_q;
    msg_d   = 1'b0;

    case (state_q)
      S_COLLECT: begin
        if (accept) begin
          case (Signals)
            SIG_DOT, SIG_DASH: begin
              if (len_q == 3'd5) begin
                ovf_d = 1'b1;
              end else begin
                pat_d = {pat_q[3:0], Signals[0]};
                len_d = len_q + 3'd1;
              end
            end
            SIG_SPACE: begin
              if (len_q != 3'd0) begin
                valid_d = 1'b1;
                ascii_d = letter_bad ? ERR_CHAR : decoded[7:0];
                err_d   = letter_bad;
              end else if (WORD_SPACE_EN) begin
                valid_d = 1'b1;
                ascii_d = 8'h20;
                err_d   = 1'b0;
              end
              pat_d = 5'd0;
              len_d = 3'd0;
              ovf_d = 1'b0;
            end
            default: begin // SIG_END
              if (len_q != 3'd0) begin
                valid_d = 1'b1;
                ascii_d = letter_bad ? ERR_CHAR : decoded[7:0];
                err_d   = letter_bad;
              end else begin
                msg_d = 1'b1;
              end
              pat_d   = 5'd0;
              len_d   = 3'd0;
              ovf_d   = 1'b0;
              state_d = S_END;
            end
          endcase
        end
      end
      default: begin // S_END
        // An empty-letter EndSeq already pulsed msg_end on entry; otherwise pulse it now.
        msg_d   = ~msg_q;
        state_d = S_COLLECT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
    if (rst) begin
      state_q <= S_COLLECT;
      prev_q  <= SIG_IDLE;
      pat_q   <= 5'd0;
      len_q   <= 3'd0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      ascii_q <= 8'h00;
      err_q   <= 1'b0;
      msg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= Signals;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      ascii_q <= ascii_d;
      err_q   <= err_d;
      msg_q   <= msg_d;
    end
  end

  assign char_valid = valid_q;
  assign char_ascii = ascii_q;
  assign char_err   = err_q;
  assign msg_end    = msg_q;
  assign sym_count  = len_q;

endmodule
